// File: rtl/acs_array.sv
// Add-compare-select array for the Viterbi path-metric unit: one trellis step per
// valid beat (saturating add, compare, select), then normalisation by the minimum metric.

module acs_lane #(
    parameter int BM_W = 2,
    parameter int PM_W = 4
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [BM_W-1:0] bm0,
    input  logic [BM_W-1:0] bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);
    localparam logic [PM_W-1:0] PM_MAX = '1;

    // PM_MAX acts as infinity: any sum reaching it, including a PM_MAX operand, clamps there
    function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] pm, input logic [BM_W-1:0] bm);
        logic [PM_W:0] sum;
        sum = {1'b0, pm} + {{(PM_W+1-BM_W){1'b0}}, bm};
        if (sum >= {1'b0, PM_MAX}) return PM_MAX;
        return sum[PM_W-1:0];
    endfunction

    logic [PM_W-1:0] c0, c1;

    assign c0     = sat_add(pm0, bm0);
    assign c1     = sat_add(pm1, bm1);
    assign dec    = (c1 < c0);
    assign pm_new = dec ? c1 : c0;
endmodule

module acs_array #(
    parameter int NUM_STATES = 4,
    parameter int BM_W       = 2,
    parameter int PM_W       = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_init,
    input  logic                             i_valid,
    input  logic [2*NUM_STATES*BM_W-1:0]     i_BM,
    output logic                             o_valid,
    output logic [NUM_STATES-1:0]            o_dec,
    output logic [$clog2(NUM_STATES)-1:0]    o_min_state,
    output logic [NUM_STATES*PM_W-1:0]       o_pm
);
    localparam int M = $clog2(NUM_STATES);
    localparam logic [PM_W-1:0] PM_MAX = '1;

    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_new, pm_norm;
    logic [NUM_STATES-1:0]           dec_c, dec_q;
    logic [PM_W-1:0]                 min_val;
    logic [M-1:0]                    min_idx, min_q;
    logic                            valid_q;

    // Predecessor j of state s is {j, s[M-1:1]}: the new input bit enters at the LSB
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_lane
        localparam int P0 = s / 2;
        localparam int P1 = s / 2 + NUM_STATES / 2;

        acs_lane #(.BM_W(BM_W), .PM_W(PM_W)) u_lane (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (i_BM[(2*s)*BM_W +: BM_W]),
            .bm1    (i_BM[(2*s+1)*BM_W +: BM_W]),
            .pm_new (pm_new[s]),
            .dec    (dec_c[s])
        );

        assign pm_norm[s] = (pm_new[s] == PM_MAX) ? PM_MAX : pm_new[s] - min_val;
    end

    // Strict compare keeps the lowest index on ties
    always_comb begin
        min_val = pm_new[0];
        min_idx = '0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (pm_new[s] < min_val) begin
                min_val = pm_new[s];
                min_idx = M'(s);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_init) begin
            for (int s = 0; s < NUM_STATES; s++)
                pm_q[s] <= (s == 0) ? '0 : PM_MAX;
            dec_q   <= '0;
            min_q   <= '0;
            valid_q <= 1'b0;
        end else if (i_valid) begin
            pm_q    <= pm_norm;
            dec_q   <= dec_c;
            min_q   <= min_idx;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign o_pm        = pm_q;
    assign o_dec       = dec_q;
    assign o_min_state = min_q;
    assign o_valid     = valid_q;
endmodule

// File: doc/acs_array.md
# acs_array

Parametrised add-compare-select array for the Viterbi decoder path-metric unit, generalising the 2-bit saturating PM+BM adder to an N-state trellis. It holds all path metrics in registers and performs one trellis step per valid beat: saturating add, compare, select, then normalisation by the minimum metric. It sits between the branch-metric unit and the survivor/traceback memory, supplying per-state decision bits and the best-state index.

## Interface
- `NUM_STATES`, 4: trellis states; power of 2, ≥2; M = log2(NUM_STATES)
- `BM_W`, 2: branch-metric width
- `PM_W`, 4: path-metric width; PM_W > BM_W; PM_MAX = 2^PM_W−1
- `i_clk` in 1: clock
- `i_rst` in 1: reset; one clock, synchronous, active-high
- `i_init` in 1: synchronous re-start of the trellis (same effect as reset on metrics)
- `i_valid` in 1: i_BM valid, perform one step this cycle
- `i_BM` in 2·NUM_STATES·BM_W: slice (2s+j)·BM_W +: BM_W = metric of branch from predecessor j into state s
- `o_valid` in→out 1: step result valid (1-cycle pulse per step)
- `o_dec` out NUM_STATES: bit s = selected predecessor j for state s
- `o_min_state` out M: index of smallest post-step metric
- `o_pm` out NUM_STATES·PM_W: registered metrics, slice s·PM_W +: PM_W = PM[s]

## Operation
- Predecessors of state s: p_j = {j, s[M−1:1]}, j∈{0,1} (new input bit enters LSB).
- Candidate c_j = sat(PM[p_j] + BM(s,j)); sat clamps to PM_MAX. PM_MAX is "infinity": any add with PM_MAX operand yields PM_MAX.
- Select: new[s] = min(c_0, c_1); dec[s] = 1 only if c_1 < c_0 (tie → j=0).
- Minimum: m = min over new[s]; o_min_state = lowest index achieving m.
- Normalise: PM[s] ← new[s] − m, except new[s]=PM_MAX stays PM_MAX. After any step the minimum stored metric is 0 unless all are PM_MAX (then m=PM_MAX, all remain PM_MAX).
- i_valid low: PM, o_dec, o_min_state hold; o_valid 0.
- Reset / i_init: PM[0]=0, PM[s≠0]=PM_MAX (known start state 0); o_dec=0, o_min_state=0, o_valid=0.
- i_init and i_valid same cycle: init wins, step discarded, o_valid=0 next cycle.
- i_rst dominates i_init and i_valid; reset mid-stream discards any step in flight.

## Timing
- Single register stage: step sampled on edge k (i_valid=1) → o_pm, o_dec, o_min_state, o_valid=1 visible after edge k, i.e. latency 1 cycle.
- Throughput: one step per cycle; back-to-back i_valid fully supported, each step uses PM registered by previous step.
- o_valid deasserts cycle after i_valid drops; no backpressure.
- Add, compare, select, min-tree, subtract are all combinational within one cycle.

## Test plan
(Defaults: NUM_STATES=4, BM_W=2, PM_W=4, PM_MAX=15; o_pm listed PM[3..0].)
- Reset: assert i_rst 1 cycle → o_pm={15,15,15,0}, o_dec=0000, o_min_state=0, o_valid=0.
- First step: after reset, i_valid=1, all BM=0 → next cycle o_valid=1, o_pm={15,15,0,0}, o_dec=0000, o_min_state=0.
- Normalisation: from {15,15,0,0}, all BM=2 → new all 2, m=2 → o_pm={0,0,0,0}, o_dec=0000, o_min_state=0.
- Decision/tie: from all-zero, BM(s,0)=1, BM(s,1)=0 for all s → o_dec=1111, o_pm={0,0,0,0}; repeat with all BM equal → o_dec=0000.
- Saturation: drive PM[p]=14 via sequence, BM=3 on its branch, other candidate PM_MAX → that state stores 15 before normalise and stays 15 after; all-PM_MAX case → o_pm={15,15,15,15}, o_min_state=0.
- Control corners: i_init with i_valid → o_valid=0, o_pm={15,15,15,0}; i_valid low 3 cycles → outputs hold; i_rst during back-to-back stream → reset values next cycle, no o_valid.
